key_scheduler: RTL
==================

# key_scheduler

Turns the seven raw piano key switches and octave switches into the single `note`/`octave` pair that drives the square-wave tone generator. Each key is synchronised and debounced. The block then picks one sounding note: either the last-pressed key (legato mode) or a timed ascending cycle through all held keys (arpeggio mode). It sits between the board switch inputs and the tone generator, and is the only source of that generator's note/octave.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable clocks (10 ms at 100 MHz) needed to accept a key change; must be ≥2.
- `ARP_CYCLES`, default 12500000: clocks per arpeggio step (125 ms); must be ≥2.

Ports:
- `clk_100M` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `keys` in 7: raw asynchronous key levels, active-high; bit i maps to note code i+1 (C..B).
- `octave_in` in 3: octave select switches (quasi-static).
- `arp_en` in 1: 1 selects arpeggio mode, 0 selects legato mode. Passed through the same 2-flop synchroniser as the keys, but not debounced.
- `note_out` out 3: note code to the tone generator; 0 means silence.
- `octave_out` out 3: octave to the tone generator.
- `note_valid` out 1: high when `note_out` is non-zero.

## Operation
- Synchronisation: each `keys` bit and `arp_en` goes through a 2-flop synchroniser.
- Debounce, one per key:
  - Each key has its own counter, width ceil(log2(DEBOUNCE_CYCLES)).
  - The counter clears whenever the synced key equals the debounced state.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state flips on that edge and the counter clears.
  - A press or release event is a one-cycle pulse on a debounced 0→1 or 1→0 transition.
- `held[6:0]` is the debounced key vector.
- State machine states: IDLE, LEGATO, ARP.
  - IDLE:
    - `note_out`=0.
    - Any press event with `arp_en`=0 goes to LEGATO.
    - Any press event with `arp_en`=1 goes to ARP.
  - LEGATO:
    - A press event sets `note_out` to that key's code.
    - Simultaneous press events: the highest key index wins.
    - Release of the sounding key:
      - If other keys are held, `note_out` becomes the code of the highest-index held key.
      - If no key is held, `note_out`=0 and the state goes to IDLE.
    - Release of a non-sounding key leaves `note_out` unchanged.
    - `arp_en` rising goes to ARP.
  - ARP:
    - Step timer runs from 0 to ARP_CYCLES-1, then wraps.
    - On the wrap edge, `note_out` advances to the next held key above the current index, wrapping from B to C.
    - If the current key is the only held key, `note_out` stays on it.
    - On entry, the timer clears and `note_out` becomes the lowest held key.
    - A press event does not change `note_out` until the next step.
    - Release of the sounding key forces an immediate step to the next held key and clears the timer.
    - No keys held: `note_out`=0 and the state goes to IDLE.
    - `arp_en` falling goes to LEGATO, with `note_out` set to the highest held key.
- Octave: `octave_out` loads `octave_in` only on edges where `note_out` changes to a new non-zero value. A running note never changes pitch because `octave_in` moved.
- `note_valid` is (`note_out` != 0).

## Timing
- Reset (asynchronous, `rst_n`=0):
  - Outputs: `note_out`=0, `octave_out`=0, `note_valid`=0.
  - Internals: all synchronisers, `held` and debounce counters cleared; state IDLE; arpeggio timer 0.
  - Asserting reset mid-note silences the output immediately.
  - After deassertion, keys already held are accepted only after a full debounce.
- Latency from a raw key edge to `note_out`: exactly 2 (sync) + DEBOUNCE_CYCLES + 1 (register) clocks.
- A glitch shorter than DEBOUNCE_CYCLES clocks produces no event.
- All outputs are registered; they change only on `clk_100M` rising edges.
- `note_out` and `octave_out` update on the same edge.
- A mode change on `arp_en` takes effect 3 clocks after the raw edge.
- Arpeggio step period is exactly ARP_CYCLES clocks while the held set is stable.

## Test plan
Run with DEBOUNCE_CYCLES=4 and ARP_CYCLES=8.
1. Reset then legato press: assert `rst_n`=0 → `note_out`=0, `octave_out`=0, `note_valid`=0. With `octave_in`=2, raise `keys[0]` → exactly 7 clocks later `note_out`=1, `octave_out`=2, `note_valid`=1.
2. Bounce rejection: toggle `keys[3]` with high pulses 3 clocks wide → `note_out` stays 0. Then hold the key steady → `note_out`=4.
3. Legato priority: hold key 1, then press key 5 → `note_out`=6. Release key 5 → `note_out`=2. Press keys 2 and 4 in the same cycle → `note_out`=5. Release all → `note_out`=0, state IDLE.
4. Arpeggio: `arp_en`=1, hold keys 0, 2, 6 → sequence 1, 3, 7, 1, ... changing every 8 clocks. Release key 2 while 3 sounds → `note_out`=7 the next clock, and the timer restarts.
5. Octave latch: hold key 4 with `octave_in`=1, then change `octave_in` to 5 → `octave_out` stays 1. Press key 6 → `octave_out`=5 on the same edge as `note_out`=7.
6. Reset mid-arpeggio: pull `rst_n` low while `note_out`=3 → `note_out`=0 asynchronously. Release reset with keys still held → `note_out`=0 for 6 clocks, then non-zero.

Source files
------------

// File: rtl/key_scheduler.sv
// key_scheduler: debounces the seven piano keys and selects one sounding
// note (last-pressed in legato mode, timed ascending cycle in arpeggio mode)
// plus its latched octave for the square-wave tone generator.
module key_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ARP_CYCLES      = 12500000
) (
    input  logic       clk_100M,
    input  logic       rst_n,
    input  logic [6:0] keys,
    input  logic [2:0] octave_in,
    input  logic       arp_en,
    output logic [2:0] note_out,
    output logic [2:0] octave_out,
    output logic       note_valid
);

    localparam int          NK    = 7;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMR_W = (ARP_CYCLES > 2) ? $clog2(ARP_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARP_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LEGATO = 2'd1;
    localparam logic [1:0] S_ARP    = 2'd2;

    logic [6:0]       keys_s1_q, keys_s2_q;
    logic             arp_s1_q, arp_s2_q;
    logic [DB_W-1:0]  db_cnt_q [NK];
    logic [DB_W-1:0]  db_cnt_d [NK];
    logic [6:0]       held_q, held_d;
    logic [6:0]       press_q;
    logic [1:0]       state_q, state_d;
    logic [2:0]       note_q, note_d;
    logic [2:0]       octave_q, octave_d;
    logic             valid_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             sounding_held_c;

    // Code of the highest set bit (0 when empty).
    function automatic logic [2:0] hi_code(input logic [6:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NK; i++) begin
            if (v[3'(i)]) r = 3'(i + 1);
        end
        return r;
    endfunction

    // Code of the lowest set bit (0 when empty).
    function automatic logic [2:0] lo_code(input logic [6:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (v[3'(i)]) r = 3'(i + 1);
        end
        return r;
    endfunction

    // Next held key strictly above cur, wrapping B->C; cur itself if it is the only one.
    function automatic logic [2:0] next_code(input logic [6:0] h, input logic [2:0] cur);
        logic [2:0] r;
        int         idx;
        r = cur;
        for (int k = NK; k >= 1; k--) begin
            idx = (int'(cur) + NK - 1 + k) % NK;
            if (h[3'(idx)]) r = 3'(idx + 1);
        end
        return r;
    endfunction

    // Two-flop synchronisers for keys and mode switch.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            keys_s1_q <= '0;
            keys_s2_q <= '0;
            arp_s1_q  <= 1'b0;
            arp_s2_q  <= 1'b0;
        end else begin
            keys_s1_q <= keys;
            keys_s2_q <= keys_s1_q;
            arp_s1_q  <= arp_en;
            arp_s2_q  <= arp_s1_q;
        end
    end

    // Per-key debounce: count disagreeing cycles, flip on the last one.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < NK; i++) begin
            db_cnt_d[3'(i)] = '0;
            if (keys_s2_q[3'(i)] != held_q[3'(i)]) begin
                if (db_cnt_q[3'(i)] == DB_LAST) begin
                    held_d[3'(i)] = ~held_q[3'(i)];
                end else begin
                    db_cnt_d[3'(i)] = db_cnt_q[3'(i)] + DB_W'(1);
                end
            end
        end
    end

    // Debounced state, counters and one-cycle press pulses.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) db_cnt_q[3'(i)] <= '0;
            held_q  <= '0;
            press_q <= '0;
        end else begin
            for (int i = 0; i < NK; i++) db_cnt_q[3'(i)] <= db_cnt_d[3'(i)];
            held_q  <= held_d;
            press_q <= held_d & ~held_q;
        end
    end

    // Is the currently sounding key still held.
    always_comb begin
        sounding_held_c = 1'b0;
        for (int i = 0; i < NK; i++) begin
            if (note_q == 3'(i + 1)) sounding_held_c = held_q[3'(i)];
        end
    end

    // Mode FSM and note selection; octave latches only on a new non-zero note.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        tmr_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|press_q) begin
                    if (arp_s2_q) begin
                        state_d = S_ARP;
                        note_d  = lo_code(held_q);
                    end else begin
                        state_d = S_LEGATO;
                        note_d  = hi_code(press_q);
                    end
                end
            end
            S_LEGATO: begin
                if (arp_s2_q) begin
                    if (held_q == '0) begin
                        state_d = S_IDLE;
                        note_d  = '0;
                    end else begin
                        state_d = S_ARP;
                        note_d  = lo_code(held_q);
                    end
                end else if (|press_q) begin
                    note_d = hi_code(press_q);
                end else if (!sounding_held_c) begin
                    if (|held_q) begin
                        note_d = hi_code(held_q);
                    end else begin
                        state_d = S_IDLE;
                        note_d  = '0;
                    end
                end
            end
            S_ARP: begin
                if (held_q == '0) begin
                    state_d = S_IDLE;
                    note_d  = '0;
                end else if (!arp_s2_q) begin
                    state_d = S_LEGATO;
                    note_d  = hi_code(held_q);
                end else if (!sounding_held_c || (tmr_q == TMR_LAST)) begin
                    note_d = next_code(held_q, note_q);
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                note_d  = '0;
            end
        endcase
        octave_d = ((note_d != '0) && (note_d != note_q)) ? octave_in : octave_q;
    end

    // FSM and output registers.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            note_q   <= '0;
            octave_q <= '0;
            valid_q  <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            octave_q <= octave_d;
            valid_q  <= (note_d != '0);
            tmr_q    <= tmr_d;
        end
    end

    assign note_out   = note_q;
    assign octave_out = octave_q;
    assign note_valid = valid_q;

endmodule
